// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types for the count sequencer slice.
// Holds the controller state encoding and the direction constants used by
// both the controller and the counter core.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Direction encoding: up counts toward all-ones, down counts toward zero.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_seq_core.sv
// count_seq_core: WIDTH-bit up/down counter register for the count sequencer.
// Loads a value, steps by one in the selected direction, and reports whether
// the current value is the terminal value or one step away from it.
module count_seq_core
  import count_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  input  logic             i_step,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_q,
  output logic             o_atTerminal,
  output logic             o_preTerminal
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nextQ;
  logic [WIDTH-1:0] w_terminal;

  assign w_terminal = (i_dir == DIR_DOWN) ? '0 : '1;

  // Pick the next counter value: load wins over a step, otherwise hold.
  always_comb begin
    w_nextQ = r_q;
    if (i_load) begin
      w_nextQ = i_loadValue;
    end else if (i_step) begin
      w_nextQ = (i_dir == DIR_DOWN) ? (r_q - WIDTH'(1)) : (r_q + WIDTH'(1));
    end
  end

  // Counter register; cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= w_nextQ;
    end
  end

  assign o_q           = r_q;
  assign o_atTerminal  = (r_q == w_terminal);
  assign o_preTerminal = (i_dir == DIR_DOWN) ? (r_q == WIDTH'(1)) : (r_q == ~WIDTH'(1));

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: commandable controller for a WIDTH-bit up/down counter.
// Accepts run commands over valid/ready, then loads, steps, holds, reloads
// or finishes, and reports busy, terminal-count and done pulses.
// Optional feature macro: COUNT_SEQ_PRESCALE_EN adds the prescale_div port
// and a prescaler that slows stepping to one step per prescale_div+1 cycles.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH = 4
`ifdef COUNT_SEQ_PRESCALE_EN
  ,
  parameter int PRESCALE_W = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WIDTH-1:0]      cmd_load,
  input  logic                  cmd_dir,
  input  logic                  cmd_auto,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale_div,
`endif
  input  logic                  hold,
  input  logic                  abort,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic                  tc,
  output logic                  done
);

  function automatic logic isTerminal(input logic [WIDTH-1:0] value, input logic dir);
    return (dir == DIR_DOWN) ? (value == '0) : (value == '1);
  endfunction

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_loadVal;
  logic             r_dir;
  logic             r_auto;
  logic             r_busy;
  logic             r_tc;
  logic             r_done;

  logic [WIDTH-1:0] w_loadValue;
  logic [WIDTH-1:0] w_q;
  logic             w_load;
  logic             w_step;
  logic             w_dirSel;
  logic             w_accept;
  logic             w_event;
  logic             w_hitTerm;
  logic             w_finish;
  logic             w_atTerm;
  logic             w_preTerm;
  logic             w_cmdAtTerm;
  logic             w_reloadAtTerm;
  logic             w_stepEn;

  assign cmd_ready      = (r_state == IDLE) && !rst && !abort;
  assign w_dirSel       = (r_state == IDLE) ? cmd_dir : r_dir;
  assign w_cmdAtTerm    = isTerminal(cmd_load, cmd_dir);
  assign w_reloadAtTerm = isTerminal(r_loadVal, r_dir);

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_div;
  logic [PRESCALE_W-1:0] r_pre;
  logic                  w_active;

  assign w_active = (r_state == RUN) || (r_state == HOLD);
  assign w_stepEn = (r_pre == r_div);

  // Prescaler counts enabled run cycles and clears on expiry, load and abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (abort || w_accept) begin
      r_pre <= '0;
    end else if (w_active && !hold) begin
      r_pre <= w_stepEn ? '0 : (r_pre + PRESCALE_W'(1));
    end
  end
`else
  assign w_stepEn = 1'b1;
`endif

  count_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_loadValue  (w_loadValue),
    .i_step       (w_step),
    .i_dir        (w_dirSel),
    .o_q          (w_q),
    .o_atTerminal (w_atTerm),
    .o_preTerminal(w_preTerm)
  );

  // Next-state and counter control: abort first, then handshake or stepping.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_loadValue = r_loadVal;
    w_step      = 1'b0;
    w_accept    = 1'b0;
    w_event     = 1'b0;
    w_hitTerm   = 1'b0;
    w_finish    = 1'b0;
    if (abort) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            w_accept    = 1'b1;
            w_load      = 1'b1;
            w_loadValue = cmd_load;
            w_event     = 1'b1;
            w_hitTerm   = w_cmdAtTerm;
            w_finish    = !cmd_auto && w_cmdAtTerm;
            w_nextState = w_finish ? IDLE : RUN;
          end
        end
        RUN, HOLD: begin
          if (hold) begin
            w_nextState = HOLD;
          end else begin
            w_nextState = RUN;
            if (w_stepEn) begin
              if (!w_atTerm) begin
                w_step    = 1'b1;
                w_event   = 1'b1;
                w_hitTerm = w_preTerm;
              end else if (r_auto) begin
                w_load    = 1'b1;
                w_event   = 1'b1;
                w_hitTerm = w_reloadAtTerm;
              end else begin
                w_nextState = IDLE;
              end
              if (!r_auto && w_event && w_hitTerm) begin
                w_finish    = 1'b1;
                w_nextState = IDLE;
              end
            end
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // State, status pulses and the command latch captured at the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_tc      <= 1'b0;
      r_done    <= 1'b0;
      r_loadVal <= '0;
      r_dir     <= 1'b0;
      r_auto    <= 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
      r_div     <= '0;
`endif
    end else begin
      r_state <= w_nextState;
      r_busy  <= (w_nextState != IDLE);
      r_tc    <= w_event && w_hitTerm;
      r_done  <= w_finish;
      if (w_accept) begin
        r_loadVal <= cmd_load;
        r_dir     <= cmd_dir;
        r_auto    <= cmd_auto;
`ifdef COUNT_SEQ_PRESCALE_EN
        r_div     <= prescale_div;
`endif
      end
    end
  end

  assign q    = w_q;
  assign busy = r_busy;
  assign tc   = r_tc;
  assign done = r_done;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed self-checking bench for count_sequencer
// (WIDTH=4). Prescaler scenarios build only with COUNT_SEQ_PRESCALE_EN.
module tb_count_sequencer;
  import count_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_load;
  logic       cmd_dir;
  logic       cmd_auto;
  logic       hold;
  logic       abort;
  logic [3:0] q;
  logic       busy;
  logic       tc;
  logic       done;
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [7:0] prescale_div;
`endif

  logic [6:0] status;
  int checkCount = 0;
  int passCount  = 0;

  assign status = {q, busy, tc, done};

  always #5 clk = ~clk;

  count_sequencer #(
    .WIDTH(4)
`ifdef COUNT_SEQ_PRESCALE_EN
    , .PRESCALE_W(8)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_dir     (cmd_dir),
    .cmd_auto    (cmd_auto),
`ifdef COUNT_SEQ_PRESCALE_EN
    .prescale_div(prescale_div),
`endif
    .hold        (hold),
    .abort       (abort),
    .q           (q),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  // Reset at start and again mid-run; ready must return right after release.
  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 4'd0; cmd_dir = DIR_UP;
    cmd_auto = 1'b0; hold = 1'b0; abort = 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
    prescale_div = 8'd0;
`endif
    repeat (2) @(negedge clk);
    checkCount++;
    if (status !== 7'b0000_000) $display("[TB] FAIL reset_init {q,busy,tc,done}: got %b expected %b", status, 7'b0000_000);
    else passCount++;
    checkCount++;
    if (cmd_ready !== 1'b0) $display("[TB] FAIL reset_ready_low: got %b expected 0", cmd_ready);
    else passCount++;
    rst = 1'b0; cmd_valid = 1'b1; cmd_load = 4'd9; cmd_dir = DIR_DOWN; cmd_auto = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkCount++;
    if (status !== {4'd9, 3'b100}) $display("[TB] FAIL reset_run_load: got %b expected %b", status, {4'd9, 3'b100});
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (status !== {4'd8, 3'b100}) $display("[TB] FAIL reset_run_step: got %b expected %b", status, {4'd8, 3'b100});
    else passCount++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkCount++;
    if (status !== 7'b0000_000) $display("[TB] FAIL reset_midrun: got %b expected %b", status, 7'b0000_000);
    else passCount++;
    rst = 1'b0;
    #1;
    checkCount++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b expected 1", cmd_ready);
    else passCount++;
  endtask

  // One-shot down from 5: 5,4,3,2,1,0 with tc/done only at 0.
  task automatic test_oneshot_down();
    logic [6:0] expected;
    cmd_valid = 1'b1; cmd_load = 4'd5; cmd_dir = DIR_DOWN; cmd_auto = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      expected = {4'(5 - i), (i < 5), (i == 5), (i == 5)};
      checkCount++;
      if (status !== expected) $display("[TB] FAIL oneshot_down[%0d]: got %b expected %b", i, status, expected);
      else passCount++;
    end
    checkCount++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL oneshot_ready_after_done: got %b expected 1", cmd_ready);
    else passCount++;
  endtask

  // Commands issued in the cycle right after done, each loading its terminal.
  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_load = 4'd15; cmd_dir = DIR_UP; cmd_auto = 1'b0;
    @(negedge clk);
    checkCount++;
    if (status !== {4'd15, 3'b011}) $display("[TB] FAIL b2b_load_term_up: got %b expected %b", status, {4'd15, 3'b011});
    else passCount++;
    cmd_load = 4'd0; cmd_dir = DIR_DOWN;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkCount++;
    if (status !== {4'd0, 3'b011}) $display("[TB] FAIL b2b_load_term_down: got %b expected %b", status, {4'd0, 3'b011});
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (status !== {4'd0, 3'b000}) $display("[TB] FAIL b2b_idle_after: got %b expected %b", status, {4'd0, 3'b000});
    else passCount++;
  endtask

  // Auto-reload up from 13: period of three with tc on every 15, then abort.
  task automatic test_auto_up();
    logic [6:0] expected;
    cmd_valid = 1'b1; cmd_load = 4'd13; cmd_dir = DIR_UP; cmd_auto = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      expected = {4'(13 + (i % 3)), 1'b1, ((i % 3) == 2), 1'b0};
      checkCount++;
      if (status !== expected) $display("[TB] FAIL auto_up[%0d]: got %b expected %b", i, status, expected);
      else passCount++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkCount++;
    if (status !== {4'd15, 3'b000}) $display("[TB] FAIL auto_abort: got %b expected %b", status, {4'd15, 3'b000});
    else passCount++;
  endtask

  // Down from 9, hold for four cycles at 6, then resume to 0.
  task automatic test_hold();
    logic [6:0] expected;
    cmd_valid = 1'b1; cmd_load = 4'd9; cmd_dir = DIR_DOWN; cmd_auto = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      expected = {4'(9 - i), 3'b100};
      checkCount++;
      if (status !== expected) $display("[TB] FAIL hold_pre[%0d]: got %b expected %b", i, status, expected);
      else passCount++;
    end
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) hold = 1'b0;
      checkCount++;
      if (status !== {4'd6, 3'b100}) $display("[TB] FAIL hold_frozen[%0d]: got %b expected %b", i, status, {4'd6, 3'b100});
      else passCount++;
    end
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      expected = {4'(5 - i), (i < 5), (i == 5), (i == 5)};
      checkCount++;
      if (status !== expected) $display("[TB] FAIL hold_resume[%0d]: got %b expected %b", i, status, expected);
      else passCount++;
    end
  endtask

  // Abort at q=3 with a command offered; abort also blocks the IDLE handshake.
  task automatic test_abort();
    logic [6:0] expected;
    cmd_valid = 1'b1; cmd_load = 4'd5; cmd_dir = DIR_DOWN; cmd_auto = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      expected = {4'(5 - i), 3'b100};
      checkCount++;
      if (status !== expected) $display("[TB] FAIL abort_pre[%0d]: got %b expected %b", i, status, expected);
      else passCount++;
    end
    abort = 1'b1; cmd_valid = 1'b1; cmd_load = 4'd10; cmd_dir = DIR_UP; cmd_auto = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkCount++;
      if (cmd_ready !== 1'b0) $display("[TB] FAIL abort_ready_low[%0d]: got %b expected 0", i, cmd_ready);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (status !== {4'd3, 3'b000}) $display("[TB] FAIL abort_idle[%0d]: got %b expected %b", i, status, {4'd3, 3'b000});
      else passCount++;
    end
    abort = 1'b0;
    #1;
    checkCount++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL abort_ready_back: got %b expected 1", cmd_ready);
    else passCount++;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      expected = {4'(10 + i), (i < 5), (i == 5), (i == 5)};
      checkCount++;
      if (status !== expected) $display("[TB] FAIL abort_retry[%0d]: got %b expected %b", i, status, expected);
      else passCount++;
    end
  endtask

`ifdef COUNT_SEQ_PRESCALE_EN
  // div=2 down from 2 steps every third cycle; div=0 with terminal load finishes at once.
  task automatic test_prescale();
    logic [6:0] expected;
    cmd_valid = 1'b1; cmd_load = 4'd2; cmd_dir = DIR_DOWN; cmd_auto = 1'b0; prescale_div = 8'd2;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      expected = {4'(2 - (i / 3)), (i < 6), (i == 6), (i == 6)};
      checkCount++;
      if (status !== expected) $display("[TB] FAIL prescale_div2[%0d]: got %b expected %b", i, status, expected);
      else passCount++;
    end
    cmd_valid = 1'b1; cmd_load = 4'd15; cmd_dir = DIR_UP; prescale_div = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkCount++;
    if (status !== {4'd15, 3'b011}) $display("[TB] FAIL prescale_div0_term: got %b expected %b", status, {4'd15, 3'b011});
    else passCount++;
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_oneshot_down();
    test_back_to_back();
    test_auto_up();
    test_hold();
    test_abort();
`ifdef COUNT_SEQ_PRESCALE_EN
    test_prescale();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, checks so far %0d", checkCount);
    $fatal(1, "[TB] timeout");
  end

endmodule
